// File: rtl/stall_ctrl.sv
// Stall/flush controller for the 6-stage in-order pipeline (PC, IF, ID, EX, MEM, WB).
// Optional stall-cycle performance counter is enabled with `define STALL_CTRL_PERF_EN.
module stall_ctrl #(
    parameter int MC_LEN_W = 5,
    parameter int PC_W     = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stallreq_id,
    input  logic                ex_mc_start,
    input  logic [MC_LEN_W-1:0] ex_mc_len,
    input  logic                mem_busy,
    input  logic                redirect_req,
    input  logic [PC_W-1:0]     redirect_pc,
`ifdef STALL_CTRL_PERF_EN
    input  logic                perf_clr,
    output logic [31:0]         stall_cycles,
`endif
    output logic [5:0]          stall,
    output logic                flush,
    output logic [PC_W-1:0]     new_pc,
    output logic                ex_mc_done,
    output logic                mc_busy
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [MC_LEN_W-1:0] cnt;
    logic [MC_LEN_W-1:0] cnt_nxt;
    logic                pending;
    logic [PC_W-1:0]     pending_pc;
    logic                accept;
    logic [PC_W-1:0]     accept_pc;
    logic                long_op;
    logic                ex_stall;
    logic                done_raw;

    // A live request carries the newest PC, so it takes precedence over a pending one.
    assign accept    = (redirect_req || pending) && !mem_busy;
    assign accept_pc = redirect_req ? redirect_pc : pending_pc;
    assign long_op   = (ex_mc_len >= MC_LEN_W'(2));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            cnt        <= '0;
            flush      <= 1'b0;
            new_pc     <= '0;
            pending    <= 1'b0;
            pending_pc <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            flush <= accept;
            if (accept) begin
                new_pc  <= accept_pc;
                pending <= 1'b0;
            end else if (redirect_req) begin
                pending    <= 1'b1;
                pending_pc <= redirect_pc;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        ex_stall  = 1'b0;
        done_raw  = 1'b0;
        case (state)
            IDLE: begin
                if (ex_mc_start) begin
                    if (long_op) begin
                        ex_stall = 1'b1;
                        if (!accept) begin
                            state_nxt = BUSY;
                            cnt_nxt   = ex_mc_len - MC_LEN_W'(2);
                        end
                    end else begin
                        done_raw = 1'b1;
                    end
                end
            end
            BUSY: begin
                ex_stall = (cnt != '0) || mem_busy;
                // Acceptance implies mem_busy=0; the aborted op never reports done.
                if (accept) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (!mem_busy) begin
                    if (cnt != '0) begin
                        cnt_nxt = cnt - MC_LEN_W'(1);
                    end else begin
                        done_raw  = 1'b1;
                        state_nxt = IDLE;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_comb begin
        stall = 6'b000000;
        if (!rst || flush) begin
            stall = 6'b000000;
        end else if (mem_busy) begin
            stall = 6'b011111;
        end else if (ex_stall) begin
            stall = 6'b001111;
        end else if (stallreq_id) begin
            stall = 6'b000111;
        end
    end

    assign ex_mc_done = rst && done_raw;
    assign mc_busy    = rst && (state == BUSY);

`ifdef STALL_CTRL_PERF_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cycles <= '0;
        end else if (perf_clr) begin
            stall_cycles <= '0;
        end else if ((stall != 6'b000000) && (stall_cycles != 32'hFFFF_FFFF)) begin
            stall_cycles <= stall_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_stall_ctrl.sv
// Directed bench for stall_ctrl: inputs change 1 time unit after the rising edge,
// outputs are sampled 1 time unit later, well clear of the next edge.
module tb_stall_ctrl;

    logic        clk;
    logic        rst;
    logic        stallreq_id;
    logic        ex_mc_start;
    logic [4:0]  ex_mc_len;
    logic        mem_busy;
    logic        redirect_req;
    logic [31:0] redirect_pc;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic        ex_mc_done;
    logic        mc_busy;
`ifdef STALL_CTRL_PERF_EN
    logic        perf_clr;
    logic [31:0] stall_cycles;
`endif

    int n_cmp = 0;
    int n_err = 0;
    logic [5:0] exp_q[$];

    stall_ctrl #(.MC_LEN_W(5), .PC_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .stallreq_id  (stallreq_id),
        .ex_mc_start  (ex_mc_start),
        .ex_mc_len    (ex_mc_len),
        .mem_busy     (mem_busy),
        .redirect_req (redirect_req),
        .redirect_pc  (redirect_pc),
`ifdef STALL_CTRL_PERF_EN
        .perf_clr     (perf_clr),
        .stall_cycles (stall_cycles),
`endif
        .stall        (stall),
        .flush        (flush),
        .new_pc       (new_pc),
        .ex_mc_done   (ex_mc_done),
        .mc_busy      (mc_busy)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Driver tasks
    task automatic set_idle();
        stallreq_id  = 1'b0;
        ex_mc_start  = 1'b0;
        ex_mc_len    = 5'd0;
        mem_busy     = 1'b0;
        redirect_req = 1'b0;
        redirect_pc  = 32'h0;
`ifdef STALL_CTRL_PERF_EN
        perf_clr     = 1'b0;
`endif
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic start_op(input logic [4:0] n);
        ex_mc_start = 1'b1;
        ex_mc_len   = n;
    endtask

    int done_seen;

    initial begin
        set_idle();
        rst = 1'b0;
        // Reset held with every input active
        stallreq_id  = 1'b1;
        ex_mc_start  = 1'b1;
        ex_mc_len    = 5'd1;
        mem_busy     = 1'b1;
        redirect_req = 1'b1;
        redirect_pc  = 32'hDEAD_BEEF;
        for (int i = 0; i < 3; i++) begin
            step();
            settle();
            check_eq("rst_stall", 32'(stall), 32'h0);
            check_eq("rst_flush", 32'(flush), 32'h0);
            check_eq("rst_new_pc", new_pc, 32'h0);
            check_eq("rst_mc_busy", 32'(mc_busy), 32'h0);
            check_eq("rst_done", 32'(ex_mc_done), 32'h0);
        end
        set_idle();
        step();
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            settle();
            check_eq("post_rst_stall", 32'(stall), 32'h0);
            check_eq("post_rst_flush", 32'(flush), 32'h0);
            check_eq("post_rst_busy", 32'(mc_busy), 32'h0);
        end

        // N=5: four EX stall cycles then done in cycle 5
        for (int i = 0; i < 4; i++) exp_q.push_back(6'b001111);
        exp_q.push_back(6'b000000);
        step();
        start_op(5'd5);
        settle();
        check_eq("n5_c1_busy", 32'(mc_busy), 32'h0);
        for (int c = 1; c <= 5; c++) begin
            if (c > 1) begin
                ex_mc_start = 1'b0;
                settle();
                check_eq("n5_busy", 32'(mc_busy), 32'h1);
            end
            check_eq("n5_stall", 32'(stall), 32'(exp_q.pop_front()));
            check_eq("n5_done", 32'(ex_mc_done), (c == 5) ? 32'h1 : 32'h0);
            step();
        end
        settle();
        check_eq("n5_idle_after", 32'(mc_busy), 32'h0);
        check_eq("n5_done_after", 32'(ex_mc_done), 32'h0);

        // N=1 and N=0: done in the start cycle, no stall
        start_op(5'd1);
        settle();
        check_eq("n1_done", 32'(ex_mc_done), 32'h1);
        check_eq("n1_stall", 32'(stall), 32'h0);
        step();
        ex_mc_start = 1'b0;
        settle();
        check_eq("n1_busy", 32'(mc_busy), 32'h0);
        start_op(5'd0);
        settle();
        check_eq("n0_done", 32'(ex_mc_done), 32'h1);
        check_eq("n0_stall", 32'(stall), 32'h0);
        step();

        // N=2: one stall cycle then done
        start_op(5'd2);
        settle();
        check_eq("n2_c1_stall", 32'(stall), 32'h0F);
        check_eq("n2_c1_done", 32'(ex_mc_done), 32'h0);
        step();
        ex_mc_start = 1'b0;
        settle();
        check_eq("n2_c2_stall", 32'(stall), 32'h0);
        check_eq("n2_c2_done", 32'(ex_mc_done), 32'h1);
        step();
        check_eq("n2_after_busy", 32'(mc_busy), 32'h0);

        // Load-use alone, then load-use together with an EX stall
        stallreq_id = 1'b1;
        settle();
        check_eq("id_stall", 32'(stall), 32'h07);
        start_op(5'd3);
        settle();
        check_eq("id_ex_stall", 32'(stall), 32'h0F);
        step();
        set_idle();
        step();
        step();
        check_eq("n3_drained", 32'(mc_busy), 32'h0);

        // N=4 with mem_busy for 3 cycles: done slides from cycle 4 to cycle 7
        start_op(5'd4);
        settle();
        check_eq("n4_c1_stall", 32'(stall), 32'h0F);
        step();
        ex_mc_start = 1'b0;
        settle();
        check_eq("n4_c2_stall", 32'(stall), 32'h0F);
        step();
        for (int c = 3; c <= 5; c++) begin
            mem_busy = 1'b1;
            settle();
            check_eq("n4_mem_stall", 32'(stall), 32'h1F);
            check_eq("n4_mem_done", 32'(ex_mc_done), 32'h0);
            step();
        end
        mem_busy = 1'b0;
        settle();
        check_eq("n4_c6_stall", 32'(stall), 32'h0F);
        check_eq("n4_c6_done", 32'(ex_mc_done), 32'h0);
        step();
        settle();
        check_eq("n4_c7_stall", 32'(stall), 32'h0);
        check_eq("n4_c7_done", 32'(ex_mc_done), 32'h1);
        step();
        check_eq("n4_after_busy", 32'(mc_busy), 32'h0);

        // Redirect held behind mem_busy for 2 cycles
        mem_busy     = 1'b1;
        redirect_req = 1'b1;
        redirect_pc  = 32'h0000_0100;
        settle();
        check_eq("rd_wait1_flush", 32'(flush), 32'h0);
        step();
        redirect_req = 1'b0;
        settle();
        check_eq("rd_wait2_flush", 32'(flush), 32'h0);
        step();
        mem_busy = 1'b0;
        settle();
        check_eq("rd_accept_flush", 32'(flush), 32'h0);
        step();
        stallreq_id = 1'b1;
        settle();
        check_eq("rd_flush", 32'(flush), 32'h1);
        check_eq("rd_new_pc", new_pc, 32'h0000_0100);
        check_eq("rd_flush_stall", 32'(stall), 32'h0);
        step();
        stallreq_id = 1'b0;
        settle();
        check_eq("rd_flush_once", 32'(flush), 32'h0);

        // Newer request overwrites the pending PC
        mem_busy     = 1'b1;
        redirect_req = 1'b1;
        redirect_pc  = 32'h0000_0200;
        step();
        redirect_pc  = 32'h0000_0300;
        step();
        set_idle();
        step();
        check_eq("ovw_flush", 32'(flush), 32'h1);
        check_eq("ovw_new_pc", new_pc, 32'h0000_0300);

        // Back-to-back accepted redirects
        redirect_req = 1'b1;
        redirect_pc  = 32'h0000_0400;
        step();
        check_eq("b2b_flush1", 32'(flush), 32'h1);
        check_eq("b2b_pc1", new_pc, 32'h0000_0400);
        redirect_pc = 32'h0000_0500;
        step();
        check_eq("b2b_flush2", 32'(flush), 32'h1);
        check_eq("b2b_pc2", new_pc, 32'h0000_0500);
        set_idle();
        step();
        check_eq("b2b_flush_end", 32'(flush), 32'h0);

        // Redirect aborts an N=8 op: no done ever
        start_op(5'd8);
        step();
        ex_mc_start = 1'b0;
        step();
        redirect_req = 1'b1;
        redirect_pc  = 32'h0000_0600;
        settle();
        check_eq("abort_busy_before", 32'(mc_busy), 32'h1);
        check_eq("abort_done_req", 32'(ex_mc_done), 32'h0);
        step();
        redirect_req = 1'b0;
        settle();
        check_eq("abort_flush", 32'(flush), 32'h1);
        check_eq("abort_new_pc", new_pc, 32'h0000_0600);
        check_eq("abort_idle", 32'(mc_busy), 32'h0);
        done_seen = 0;
        for (int i = 0; i < 8; i++) begin
            if (ex_mc_done) done_seen++;
            step();
        end
        check_eq("abort_no_done", 32'(done_seen), 32'h0);
        check_eq("abort_still_idle", 32'(mc_busy), 32'h0);

        // Redirect and ex_mc_start in the same cycle: BUSY not entered
        redirect_req = 1'b1;
        redirect_pc  = 32'h0000_0700;
        start_op(5'd4);
        step();
        set_idle();
        settle();
        check_eq("same_busy", 32'(mc_busy), 32'h0);
        check_eq("same_flush", 32'(flush), 32'h1);
        step();

        // Reset mid-op with a pending redirect: everything discarded
        start_op(5'd6);
        step();
        ex_mc_start  = 1'b0;
        mem_busy     = 1'b1;
        redirect_req = 1'b1;
        redirect_pc  = 32'h0000_0800;
        step();
        rst = 1'b0;
        settle();
        check_eq("mid_rst_busy", 32'(mc_busy), 32'h0);
        check_eq("mid_rst_stall", 32'(stall), 32'h0);
        check_eq("mid_rst_new_pc", new_pc, 32'h0);
        set_idle();
        step();
        rst = 1'b1;
        step();
        check_eq("mid_rst_no_flush1", 32'(flush), 32'h0);
        step();
        check_eq("mid_rst_no_flush2", 32'(flush), 32'h0);

`ifdef STALL_CTRL_PERF_EN
        perf_clr = 1'b1;
        step();
        perf_clr = 1'b0;
        check_eq("perf_clr", stall_cycles, 32'h0);
        start_op(5'd5);
        step();
        ex_mc_start = 1'b0;
        for (int i = 0; i < 5; i++) step();
        check_eq("perf_count", stall_cycles, 32'd4);
        stallreq_id = 1'b1;
        perf_clr    = 1'b1;
        step();
        set_idle();
        check_eq("perf_clr_wins", stall_cycles, 32'h0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
